instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 112 +++++++++++
 tb/tb_instr_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction loader: streams a byte payload into instruction memory and holds the CPU until it completes.
// Latency: each accepted byte is written one cycle after acceptance; status is decoded directly from the state.
// Backpressure: byte_ready is high only while LOAD/CHECK; the stream may gap for any number of cycles.
// Optional trailing XOR check byte is enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_BYTES     = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] length,
    input  logic                     byte_valid,
    input  logic [DATA_WIDTH-1:0]    byte_data,
    output logic                     byte_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0]    wd,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     cpu_hold
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd2;
`endif
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [ADDRESS_WIDTH-1:0] MEM_LIMIT = ADDRESS_WIDTH'(MEM_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ONE       = ADDRESS_WIDTH'(1);

    logic [2:0]               state;
    logic [ADDRESS_WIDTH-1:0] cnt;
    logic [ADDRESS_WIDTH-1:0] len_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    checksum;
`endif

    logic accept;
    logic last_byte;
    logic len_ok;

    // Whole 32-bit words only, and never more than the memory holds, so wa stays below MEM_BYTES.
    assign len_ok    = (length != '0) && (length[1:0] == 2'b00) && (length <= MEM_LIMIT);
    assign accept    = byte_valid && byte_ready;
    assign last_byte = (cnt == len_r - ONE);

`ifdef INSTR_LOADER_CHECKSUM_EN
    assign busy = (state == S_LOAD) || (state == S_CHECK);
`else
    assign busy = (state == S_LOAD);
`endif
    assign byte_ready = busy;
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERROR);
    assign cpu_hold   = (state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            len_r    <= '0;
            we       <= 1'b0;
            wa       <= '0;
            wd       <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        cnt      <= '0;
                        len_r    <= length;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                        state    <= len_ok ? S_LOAD : S_ERROR;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        we       <= 1'b1;
                        wa       <= cnt;
                        wd       <= byte_data;
                        cnt      <= cnt + ONE;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        checksum <= checksum ^ byte_data;
                        if (last_byte) state <= S_CHECK;
`else
                        if (last_byte) state <= S_DONE;
`endif
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                // The check byte is consumed but never written to memory.
                S_CHECK: begin
                    if (accept) state <= (byte_data == checksum) ? S_DONE : S_ERROR;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table plus stall, reset and capacity sequences.
module tb_instr_loader;

    localparam int AW  = 32;
    localparam int DW  = 8;
    localparam int MEM = 256;

    localparam int ST_ID = 0;
    localparam int ST_LD = 1;
    localparam int ST_CK = 2;
    localparam int ST_DN = 3;
    localparam int ST_ER = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] length;
    logic          byte_valid;
    logic [DW-1:0] byte_data;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          busy;
    logic          done;
    logic          err;
    logic          cpu_hold;

    instr_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MEM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .length     (length),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          s;
        logic [AW-1:0] len;
        logic          vld;
        logic [DW-1:0] dat;
        logic          rdy;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          busy;
        logic          done;
        logic          err;
        logic          hold;
    } vec_t;

    vec_t          vecs[$];
    int            n_pass = 0;
    int            n_total = 0;
    logic          mon_en = 1'b0;
    logic [AW-1:0] mon_wa[$];
    logic [DW-1:0] mon_wd[$];

    always @(negedge clk) begin
        if (mon_en && we) begin
            mon_wa.push_back(wa);
            mon_wd.push_back(wd);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Expected status flags follow from the state the loader should be in after the edge.
    task automatic add(input logic s, input logic [AW-1:0] len, input logic vld, input logic [DW-1:0] dat,
                       input int st, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        vec_t v;
        v.s = s; v.len = len; v.vld = vld; v.dat = dat;
        v.busy = (st == ST_LD) || (st == ST_CK);
        v.rdy  = v.busy;
        v.done = (st == ST_DN);
        v.err  = (st == ST_ER);
        v.hold = (st != ST_DN);
        v.we = w; v.wa = a; v.wd = d;
        vecs.push_back(v);
    endtask

    task automatic step(input logic s, input logic [AW-1:0] len, input logic v, input logic [DW-1:0] d);
        start = s; length = len; byte_valid = v; byte_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rdy"},  byte_ready, 1'b0);
        check({tag, ".we"},   we,         1'b0);
        check({tag, ".wa"},   wa,         '0);
        check({tag, ".wd"},   wd,         '0);
        check({tag, ".busy"}, busy,       1'b0);
        check({tag, ".done"}, done,       1'b0);
        check({tag, ".err"},  err,        1'b0);
        check({tag, ".hold"}, cpu_hold,   1'b1);
    endtask

    initial begin
        int bad;
        start = 0; length = '0; byte_valid = 0; byte_data = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic load 00,A0,00,93
        add(1, 4, 0, 8'h00, ST_LD, 0, 0, 8'h00);
        add(0, 0, 1, 8'h00, ST_LD, 1, 0, 8'h00);
        add(0, 0, 1, 8'hA0, ST_LD, 1, 1, 8'hA0);
        add(0, 0, 1, 8'h00, ST_LD, 1, 2, 8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
        add(0, 0, 1, 8'h93, ST_CK, 1, 3, 8'h93);
        add(0, 0, 1, 8'h33, ST_DN, 0, 0, 8'h00);
`else
        add(0, 0, 1, 8'h93, ST_DN, 1, 3, 8'h93);
`endif
        add(0, 0, 0, 8'h00, ST_DN, 0, 0, 8'h00);
        // Bad lengths, and a stream byte offered in ERROR is not taken
        add(1, 6,       0, 8'h00, ST_ER, 0, 0, 8'h00);
        add(0, 0,       0, 8'h00, ST_ER, 0, 0, 8'h00);
        add(1, 0,       0, 8'h00, ST_ER, 0, 0, 8'h00);
        add(1, MEM + 4, 0, 8'h00, ST_ER, 0, 0, 8'h00);
        add(0, 0,       1, 8'h55, ST_ER, 0, 0, 8'h00);
        // Reload with an ignored start mid-load and valid gaps
        add(1, 4, 0, 8'h00, ST_LD, 0, 0, 8'h00);
        add(1, 6, 1, 8'h11, ST_LD, 1, 0, 8'h11);
        add(0, 0, 0, 8'h00, ST_LD, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, ST_LD, 0, 0, 8'h00);
        add(0, 0, 1, 8'h22, ST_LD, 1, 1, 8'h22);
        add(0, 0, 1, 8'h33, ST_LD, 1, 2, 8'h33);
`ifdef INSTR_LOADER_CHECKSUM_EN
        add(0, 0, 1, 8'h44, ST_CK, 1, 3, 8'h44);
        add(0, 0, 0, 8'h00, ST_CK, 0, 0, 8'h00);
        add(0, 0, 1, 8'h44, ST_DN, 0, 0, 8'h00);
        add(1, 4, 0, 8'h00, ST_LD, 0, 0, 8'h00);
        add(0, 0, 1, 8'h11, ST_LD, 1, 0, 8'h11);
        add(0, 0, 1, 8'h22, ST_LD, 1, 1, 8'h22);
        add(0, 0, 1, 8'h33, ST_LD, 1, 2, 8'h33);
        add(0, 0, 1, 8'h44, ST_CK, 1, 3, 8'h44);
        add(0, 0, 1, 8'h00, ST_ER, 0, 0, 8'h00);
`else
        add(0, 0, 1, 8'h44, ST_DN, 1, 3, 8'h44);
        add(0, 0, 0, 8'h00, ST_DN, 0, 0, 8'h00);
`endif

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].len, vecs[i].vld, vecs[i].dat);
            check($sformatf("v%0d.rdy", i),  byte_ready, vecs[i].rdy);
            check($sformatf("v%0d.we", i),   we,         vecs[i].we);
            if (vecs[i].we) begin
                check($sformatf("v%0d.wa", i), wa, vecs[i].wa);
                check($sformatf("v%0d.wd", i), wd, vecs[i].wd);
            end
            check($sformatf("v%0d.busy", i), busy,     vecs[i].busy);
            check($sformatf("v%0d.done", i), done,     vecs[i].done);
            check($sformatf("v%0d.err", i),  err,      vecs[i].err);
            check($sformatf("v%0d.hold", i), cpu_hold, vecs[i].hold);
        end

        // Stalls: 3 idle cycles between each of 8 bytes
        mon_wa.delete(); mon_wd.delete();
        mon_en = 1'b1;
        step(1, 8, 0, 8'h00);
        for (int b = 0; b < 8; b++) begin
            step(0, 0, 1, 8'(8'hC0 + b));
            repeat (3) step(0, 0, 0, 8'h00);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        step(0, 0, 1, 8'h00);
`endif
        repeat (2) step(0, 0, 0, 8'h00);
        mon_en = 1'b0;
        check("stall.count", mon_wa.size(), 8);
        for (int i = 0; i < 8 && i < mon_wa.size(); i++) begin
            check($sformatf("stall.wa%0d", i), mon_wa[i], i);
            check($sformatf("stall.wd%0d", i), mon_wd[i], 8'hC0 + i);
        end
        check("stall.done", done, 1'b1);

        // Reset after 2 of 4 bytes
        step(1, 4, 0, 8'h00);
        step(0, 0, 1, 8'hAA);
        step(0, 0, 1, 8'hBB);
        mon_wa.delete(); mon_wd.delete();
        mon_en = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) step(0, 0, 1, 8'hCC);
        mon_en = 1'b0;
        check("midrst.writes", mon_wa.size(), 0);
        check("midrst.busy", busy, 1'b0);
        check("midrst.hold", cpu_hold, 1'b1);

        // Full-capacity load with an ignored start midway
        mon_wa.delete(); mon_wd.delete();
        mon_en = 1'b1;
        step(1, MEM, 0, 8'h00);
        for (int i = 0; i < MEM; i++) begin
            step((i == 100), 4, 1, 8'(i));
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        step(0, 0, 1, 8'h00);
`endif
        repeat (2) step(0, 0, 0, 8'h00);
        mon_en = 1'b0;
        check("cap.count", mon_wa.size(), MEM);
        bad = 0;
        for (int i = 0; i < mon_wa.size(); i++) begin
            if (mon_wa[i] !== AW'(i) || mon_wd[i] !== DW'(i) || mon_wa[i] >= MEM) bad++;
        end
        check("cap.seq_errors", bad, 0);
        if (mon_wa.size() > 0) check("cap.last_wa", mon_wa[mon_wa.size()-1], MEM - 1);
        check("cap.done", done, 1'b1);
        check("cap.hold", cpu_hold, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
